instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 26 ++
 rtl/instr_fetch_pc_reg.sv | 32 +++
 rtl/instr_fetch.sv | 108 ++++++++++
 tb/tb_instr_fetch.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared constants and FSM encodings for the instruction fetch unit.
// FETCH_BOUND_CHECK_EN adds the FAULT state to the encoding.
package instr_fetch_pkg;

  localparam int unsigned INSTR_MEM_SIZE = 128;
  localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;

`ifdef FETCH_BOUND_CHECK_EN
  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;
`else
  typedef enum logic [0:0] {
    RUN = 1'b0
  } fetch_state_t;
`endif

  // Sequential successor address, wrapping to 0 at the end of instruction memory.
  function automatic logic [31:0] wrap_add4(input logic [31:0] pc, input logic [31:0] size);
    logic [31:0] sum;
    sum = pc + 32'd4;
    return (sum >= size) ? 32'd0 : sum;
  endfunction

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Program counter register with sequential next-PC and end-of-memory wrap.
module pc_reg
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int unsigned IM_SIZE  = INSTR_MEM_SIZE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  input  logic        load,
  input  logic [31:0] target,
  output logic [31:0] pc,
  output logic [31:0] next_pc
);

  localparam logic [31:0] IM_BYTES = 32'(IM_SIZE);

  assign next_pc = wrap_add4(pc, IM_BYTES);

  // A load (redirect) outranks a sequential advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= target;
    end else if (advance) begin
      pc <= next_pc;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, IF/ID pipeline register and fetch control FSM.
// Define FETCH_BOUND_CHECK_EN to halt in FAULT on misaligned or out-of-range redirects.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int unsigned IM_SIZE  = INSTR_MEM_SIZE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] InstrAddr,
  input  logic [31:0] Instr,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic        fetch_fault
);

  localparam logic [31:0] IM_BYTES = 32'(IM_SIZE);

  fetch_state_t state_reg, state_next;
  logic [31:0]  pc, next_pc, target;
  logic         pc_load, pc_advance, ifid_capture, ifid_flush;

`ifdef FETCH_BOUND_CHECK_EN
  logic target_bad;
  assign target      = redirect_pc;
  assign target_bad  = (redirect_pc[1:0] != 2'b00) || (redirect_pc > (IM_BYTES - 32'd4));
  assign fetch_fault = (state_reg == FAULT);
`else
  assign target      = (redirect_pc & ~32'h3) % IM_BYTES;
  assign fetch_fault = 1'b0;
`endif

  pc_reg #(
    .RESET_PC (RESET_PC),
    .IM_SIZE  (IM_SIZE)
  ) u_pc_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (pc_advance),
    .load    (pc_load),
    .target  (target),
    .pc      (pc),
    .next_pc (next_pc)
  );

  assign InstrAddr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Redirect wins over stall; any state other than RUN freezes everything.
  always_comb begin
    state_next   = state_reg;
    pc_load      = 1'b0;
    pc_advance   = 1'b0;
    ifid_capture = 1'b0;
    ifid_flush   = 1'b0;
    case (state_reg)
      RUN: begin
        if (redirect_valid) begin
          ifid_flush = 1'b1;
`ifdef FETCH_BOUND_CHECK_EN
          if (target_bad) begin
            state_next = FAULT;
          end else begin
            pc_load = 1'b1;
          end
`else
          pc_load = 1'b1;
`endif
        end else if (!stall) begin
          pc_advance   = 1'b1;
          ifid_capture = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_valid    <= 1'b0;
      ifid_instr    <= NOP_INSTR;
      ifid_pc       <= 32'd0;
      ifid_pc_plus4 <= 32'd0;
    end else if (ifid_flush) begin
      ifid_valid <= 1'b0;
      ifid_instr <= NOP_INSTR;
    end else if (ifid_capture) begin
      ifid_valid    <= 1'b1;
      ifid_instr    <= Instr;
      ifid_pc       <= pc;
      ifid_pc_plus4 <= next_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized scoreboard bench for instr_fetch against a behavioural fetch model.
// Model follows FETCH_BOUND_CHECK_EN the same way the DUT build does.
module tb_instr_fetch;

  localparam int IM = 128;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] Instr, InstrAddr, ifid_instr, ifid_pc, ifid_pc_plus4;
  logic        ifid_valid, fetch_fault;

  always #5 clk = ~clk;

  // Byte-addressed memory returning big-endian words combinationally.
  logic [7:0] mem_b [IM];
  logic [6:0] ra;
  assign ra    = InstrAddr[6:0];
  assign Instr = {mem_b[ra], mem_b[ra + 7'd1], mem_b[ra + 7'd2], mem_b[ra + 7'd3]};

  instr_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .InstrAddr      (InstrAddr),
    .Instr          (Instr),
    .ifid_valid     (ifid_valid),
    .ifid_instr     (ifid_instr),
    .ifid_pc        (ifid_pc),
    .ifid_pc_plus4  (ifid_pc_plus4),
    .fetch_fault    (fetch_fault)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
    logic        fault;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_pc, m_instr, m_ifpc, m_ifpc4;
  logic        m_valid, m_fault;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] a);
    int b;
    b = int'(a % IM);
    return {mem_b[b], mem_b[(b + 1) % IM], mem_b[(b + 2) % IM], mem_b[(b + 3) % IM]};
  endfunction

  task automatic model_reset();
    m_pc = 0; m_instr = 0; m_ifpc = 0; m_ifpc4 = 0; m_valid = 0; m_fault = 0;
  endtask

  // Effect of one clock edge given the inputs presented for it.
  task automatic model_step(input logic s, input logic rv, input logic [31:0] rpc);
    if (m_fault) return;
    if (rv) begin
      m_valid = 0;
      m_instr = 0;
`ifdef FETCH_BOUND_CHECK_EN
      if ((rpc % 4) != 0 || rpc > 32'(IM - 4)) m_fault = 1;
      else m_pc = rpc;
`else
      m_pc = (rpc / 4 * 4) % IM;
`endif
    end else if (!s) begin
      m_instr = model_word(m_pc);
      m_ifpc  = m_pc;
      m_pc    = (m_pc + 4) % IM;
      m_ifpc4 = m_pc;
      m_valid = 1;
    end
  endtask

  task automatic drive(input logic s, input logic rv, input logic [31:0] rpc);
    exp_t e;
    stall = s; redirect_valid = rv; redirect_pc = rpc;
    model_step(s, rv, rpc);
    e.addr = m_pc; e.instr = m_instr; e.pc = m_ifpc; e.pc4 = m_ifpc4;
    e.valid = m_valid; e.fault = m_fault;
    q.push_back(e);
  endtask

  task automatic cycle(input logic s, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    drive(s, rv, rpc);
  endtask

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  // Assert reset right now, check outputs before any clock edge, then release.
  task automatic reset_now();
    rst_n = 1'b0;
    #1;
    chk("rst_InstrAddr", InstrAddr, 32'd0);
    chk("rst_ifid_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rst_ifid_instr", ifid_instr, 32'd0);
    chk("rst_ifid_pc", ifid_pc, 32'd0);
    chk("rst_ifid_pc_plus4", ifid_pc_plus4, 32'd0);
    chk("rst_fetch_fault", {31'd0, fetch_fault}, 32'd0);
    model_reset();
    q.delete();
    stall = 0; redirect_valid = 0; redirect_pc = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    reset_now();
  endtask

  // Monitor: compares the DUT against the oldest expected entry after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("InstrAddr", InstrAddr, e.addr);
        chk("ifid_instr", ifid_instr, e.instr);
        chk("ifid_pc", ifid_pc, e.pc);
        chk("ifid_pc_plus4", ifid_pc_plus4, e.pc4);
        chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, e.valid});
        chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, e.fault});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        s, rv;
    logic [31:0] rpc;
    int          r;
    for (int i = 0; i < IM; i++) mem_b[i] = 8'($urandom);
    mem_b[0] = 8'hAA; mem_b[1] = 8'hBB; mem_b[2] = 8'hCC; mem_b[3] = 8'hDD;
    model_reset();

    // Initial reset, first fetch from RESET_PC, then three-cycle run.
    #12;
    reset_now();
    settle();
    chk("first_instr", ifid_instr, 32'hAABBCCDD);
    chk("first_pc", ifid_pc, 32'd0);
    chk("first_pc4", ifid_pc_plus4, 32'd4);
    chk("first_valid", {31'd0, ifid_valid}, 32'd1);
    cycle(0, 0, 0); cycle(0, 0, 0); settle();
    chk("run3_InstrAddr", InstrAddr, 32'd12);

    // Wrap at the end of memory.
    cycle(0, 1, 32'd124); cycle(0, 0, 0); settle();
    chk("wrap_pc", ifid_pc, 32'd124);
    chk("wrap_pc4", ifid_pc_plus4, 32'd0);
    chk("wrap_InstrAddr", InstrAddr, 32'd0);

    // Two-cycle stall at PC=8.
    cycle(0, 1, 32'd8); cycle(1, 0, 0); settle();
    chk("stall1_InstrAddr", InstrAddr, 32'd8);
    cycle(1, 0, 0); settle();
    chk("stall2_InstrAddr", InstrAddr, 32'd8);
    cycle(0, 0, 0); settle();
    chk("unstall_pc", ifid_pc, 32'd8);

    // Redirect overrides stall.
    cycle(1, 1, 32'h40); settle();
    chk("flush_valid", {31'd0, ifid_valid}, 32'd0);
    chk("flush_instr", ifid_instr, 32'd0);
    chk("flush_InstrAddr", InstrAddr, 32'h40);
    cycle(0, 0, 0); settle();
    chk("post_flush_pc", ifid_pc, 32'h40);

    // Misaligned redirect.
    cycle(0, 1, 32'h42); settle();
`ifdef FETCH_BOUND_CHECK_EN
    chk("bad_fault", {31'd0, fetch_fault}, 32'd1);
    chk("bad_InstrAddr_held", InstrAddr, 32'h44);
    cycle(0, 1, 32'h10); cycle(0, 0, 0); settle();
    chk("fault_sticky", {31'd0, fetch_fault}, 32'd1);
    chk("fault_InstrAddr_held", InstrAddr, 32'h44);
    do_reset();
    settle();
`else
    chk("misaligned_InstrAddr", InstrAddr, 32'h40);
`endif

    // Reset landing while a stall+redirect is pending for the next edge.
    @(negedge clk);
    stall = 1; redirect_valid = 1; redirect_pc = 32'h20;
    #2;
    reset_now();
    settle();
    chk("pending_discarded_pc", ifid_pc, 32'd0);
    chk("pending_discarded_instr", ifid_instr, 32'hAABBCCDD);

    // Randomized traffic with occasional mid-cycle resets.
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        do_reset();
      end else begin
        s  = ($urandom_range(0, 3) == 0);
        rv = ($urandom_range(0, 4) == 0);
        case ($urandom_range(0, 3))
          0:       rpc = $urandom_range(0, 255);
          1:       rpc = $urandom;
          default: rpc = 32'($urandom_range(0, IM / 4 - 1)) * 4;
        endcase
        cycle(s, rv, rpc);
      end
    end
    settle();
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
